ram8k_arbiter: RTL and testbench
================================

# ram8k_arbiter

Two-requester controller that shares the single-port 8 KiB synchronous RAM (2048 × 32, byte-enabled, one-cycle registered read) between the CPU instruction-fetch port and the CPU data port. It accepts picorv32-style valid/ready requests, arbitrates, and converts byte addresses to word addresses. It sequences each RAM cycle through a small FSM and returns read data or write completion to the granted requester. It sits between the core and the RAM instance; it is the only driver of the RAM control pins.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be 8 KiB aligned
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- i_valid  in  1  instruction request; held until i_ready
- i_addr  in  32  instruction byte address
- i_ready  out  1  one-cycle completion pulse, instruction port
- i_rdata  out  32  instruction read data, valid while i_ready
- d_valid  in  1  data request; held until d_ready
- d_addr  in  32  data byte address
- d_wstrb  in  4  byte write strobes; 4'b0000 = read
- d_wdata  in  32  write data
- d_ready  out  1  one-cycle completion pulse, data port
- d_rdata  out  32  data read data, valid while d_ready
- bus_err  out  1  one-cycle pulse with ready when the address was out of range
- ram_address  out  11  RAM word address
- ram_byteena  out  4  RAM byte enables
- ram_data  out  32  RAM write data
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM registered read data

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE: if any valid, choose a grant (see Configuration), latch grant, word index = (addr − BASE_ADDR)[12:2], wstrb (instruction port forces 4'b0000), and wdata. Compute in_range = ((addr − BASE_ADDR) < 8192). Go to ISSUE.
- ISSUE: RAM outputs are registered from the latched values. When in_range: ram_rden = 1 for reads and ram_wren = 1 with ram_byteena = wstrb for writes. When out of range, both enables = 0. Go to RESP.
- RESP: assert the granted port's ready for exactly one cycle.
  - Reads: rdata = ram_q.
  - Out-of-range: rdata = 0 and bus_err = 1. Writes are dropped.
  - Return to IDLE.
- The non-granted port's ready stays 0; its request remains pending.
- Address bits [1:0] are ignored. Misalignment is the core's responsibility.
- Latched request fields are frozen from IDLE exit to RESP. Requester changes after acceptance are ignored.

## Timing
- Reset values: i_ready = d_ready = bus_err = 0, i_rdata = d_rdata = 0, ram_rden = ram_wren = 0, ram_byteena = 0, ram_address = 0, ram_data = 0, grant pointer = instruction-last.
- Request accepted in cycle N (IDLE, valid high) → RAM enables high in N+1 → ready pulse in N+2, for both reads and writes.
- Maximum throughput: one access per 3 cycles. A requester holding valid after ready is treated as a new request in the following IDLE cycle.
- Simultaneous i_valid and d_valid in IDLE are resolved per the arbitration mode. The loser is served immediately after, with no idle gap beyond IDLE.
- Reset asserted mid-access aborts it immediately: all outputs return to reset values and no ready is issued. A RAM write already sampled is not undone.
- RAM enables are high for exactly one cycle per access and never while in IDLE or RESP.

## Configuration
- RAM8K_ARB_RR_EN defined: round-robin arbitration. On conflict, the port not granted last wins. The pointer updates at every grant.
- Not defined: fixed priority, with the data port always winning over the instruction port. The pointer logic is removed.

## Structure
- Shared package: FSM state encoding (IDLE/ISSUE/RESP), RAM_WORDS = 2048, RAM_AW = 11, RAM_BYTES = 8192, and the grant enum (GNT_I, GNT_D).
- Sub-module: ram8k_arb_pick, a combinational two-way picker taking both valids and the last-grant pointer and returning the grant. The round-robin/fixed selection is contained here.

## Test plan
- Data write then read: write d_addr = 0x10, d_wstrb = 4'hF, d_wdata = 0xDEADBEEF → ram_wren in N+1 with ram_address = 4 and d_ready in N+2. Then read 0x10 → d_rdata = 0xDEADBEEF.
- Byte write: write 0x10 with d_wstrb = 4'b0100 and d_wdata = 0x00AA0000 over 0xDEADBEEF → read returns 0xDEAAB EEF with the space removed, i.e. 0xDEAABEEF.
- Conflict: i_valid and d_valid both high and held for 4 requests.
  - With RAM8K_ARB_RR_EN: grants alternate D, I, D, I.
  - Without it: the data port is granted all 4 first.
- Out of range: d_addr = BASE_ADDR + 0x2000 → no RAM enable, d_ready and bus_err pulse together in N+2, d_rdata = 0.
- Reset mid-access: drop resetn during ISSUE → ram_rden, ram_wren and readies are 0 immediately. After release, a fresh read of 0x0 completes in 3 cycles.

Source files
------------

// File: rtl/ram8k_arbiter_pkg.sv
// Shared FSM encoding, RAM geometry and grant type for the 8 KiB RAM arbiter.
package ram8k_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int unsigned RAM_WORDS = 2048;
    localparam int unsigned RAM_AW    = 11;
    localparam logic [31:0] RAM_BYTES = 32'd8192;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/ram8k_arb_pick.sv
// Combinational two-way request picker.
// RAM8K_ARB_RR_EN selects round-robin; otherwise the data port has fixed priority.
module ram8k_arb_pick
    import ram8k_arbiter_pkg::*;
(
    input  logic i_ivalid,
    input  logic i_dvalid,
    input  gnt_e i_last,
    output gnt_e o_gnt
);

`ifdef RAM8K_ARB_RR_EN
    always_comb begin
        o_gnt = GNT_I;
        // On conflict the port that was not served last wins.
        if (i_ivalid && i_dvalid) begin
            o_gnt = (i_last == GNT_I) ? GNT_D : GNT_I;
        end else if (i_dvalid) begin
            o_gnt = GNT_D;
        end
    end
`else
    logic w_unused_pick;
    assign w_unused_pick = i_ivalid ^ (i_last == GNT_D);

    always_comb begin
        o_gnt = GNT_I;
        if (i_dvalid) begin
            o_gnt = GNT_D;
        end
    end
`endif

endmodule

// File: rtl/ram8k_arbiter.sv
// Shares one 2048x32 byte-enabled synchronous RAM between instruction and data ports.
// Define RAM8K_ARB_RR_EN for round-robin arbitration (default: data port priority).
module ram8k_arbiter
    import ram8k_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                i_valid,
    input  logic [31:0]         i_addr,
    output logic                i_ready,
    output logic [31:0]         i_rdata,
    input  logic                d_valid,
    input  logic [31:0]         d_addr,
    input  logic [3:0]          d_wstrb,
    input  logic [31:0]         d_wdata,
    output logic                d_ready,
    output logic [31:0]         d_rdata,
    output logic                bus_err,
    output logic [RAM_AW-1:0]   ram_address,
    output logic [3:0]          ram_byteena,
    output logic [31:0]         ram_data,
    output logic                ram_rden,
    output logic                ram_wren,
    input  logic [31:0]         ram_q
);

    logic [1:0]        r_state;
    gnt_e              r_gnt;
    logic              r_inr;
    logic              r_rd;
    logic              r_i_ready;
    logic              r_d_ready;
    logic              r_bus_err;
    logic [RAM_AW-1:0] r_address;
    logic [3:0]        r_byteena;
    logic [31:0]       r_data;
    logic              r_rden;
    logic              r_wren;

    gnt_e        w_gnt;
    gnt_e        w_last;
    logic        w_any;
    logic        w_inr;
    logic [31:0] w_off;
    logic [3:0]  w_wstrb;

`ifdef RAM8K_ARB_RR_EN
    assign w_last = r_gnt;
`else
    assign w_last = GNT_I;
`endif

    ram8k_arb_pick u_pick (
        .i_ivalid (i_valid),
        .i_dvalid (d_valid),
        .i_last   (w_last),
        .o_gnt    (w_gnt)
    );

    assign w_any   = i_valid | d_valid;
    assign w_off   = ((w_gnt == GNT_D) ? d_addr : i_addr) - BASE_ADDR;
    assign w_inr   = (w_off < RAM_BYTES);
    assign w_wstrb = (w_gnt == GNT_D) ? d_wstrb : 4'b0000;

    // RAM pins are registered at IDLE exit so the enables are live during ISSUE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= GNT_I;
            r_inr     <= 1'b0;
            r_rd      <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_bus_err <= 1'b0;
            r_address <= '0;
            r_byteena <= 4'b0000;
            r_data    <= 32'h0;
            r_rden    <= 1'b0;
            r_wren    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_bus_err <= 1'b0;
                    if (w_any) begin
                        r_gnt     <= w_gnt;
                        r_inr     <= w_inr;
                        r_rd      <= (w_wstrb == 4'b0000);
                        r_address <= w_off[RAM_AW+1:2];
                        r_byteena <= w_inr ? w_wstrb : 4'b0000;
                        r_data    <= (w_gnt == GNT_D) ? d_wdata : 32'h0;
                        r_rden    <= w_inr && (w_wstrb == 4'b0000);
                        r_wren    <= w_inr && (w_wstrb != 4'b0000);
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rden    <= 1'b0;
                    r_wren    <= 1'b0;
                    r_i_ready <= (r_gnt == GNT_I);
                    r_d_ready <= (r_gnt == GNT_D);
                    r_bus_err <= !r_inr;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ready     = r_i_ready;
    assign d_ready     = r_d_ready;
    assign bus_err     = r_bus_err;
    assign ram_address = r_address;
    assign ram_byteena = r_byteena;
    assign ram_data    = r_data;
    assign ram_rden    = r_rden;
    assign ram_wren    = r_wren;

    // Read data comes straight from the RAM output register; zero unless a valid read completes.
    assign i_rdata = (r_i_ready && r_inr && r_rd) ? ram_q : 32'h0;
    assign d_rdata = (r_d_ready && r_inr && r_rd) ? ram_q : 32'h0;

endmodule

// File: tb/tb_ram8k_arbiter.sv
// Randomized self-checking bench for ram8k_arbiter against a transaction-level RAM model.
module tb_ram8k_arbiter;
    import ram8k_arbiter_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef RAM8K_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        bus_err;
    logic [10:0] ram_address;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_data;
    logic        ram_rden;
    logic        ram_wren;
    logic [31:0] ram_q;

    always #5 clock = ~clock;

    ram8k_arbiter #(.BASE_ADDR(BASE)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .i_valid     (i_valid),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .i_rdata     (i_rdata),
        .d_valid     (d_valid),
        .d_addr      (d_addr),
        .d_wstrb     (d_wstrb),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .bus_err     (bus_err),
        .ram_address (ram_address),
        .ram_byteena (ram_byteena),
        .ram_data    (ram_data),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    // Physical RAM the arbiter drives: byte-enabled write, one-cycle registered read.
    logic [31:0] tb_mem [0:RAM_WORDS-1];
    always @(posedge clock) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) tb_mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
        if (ram_rden) ram_q <= tb_mem[ram_address];
    end

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] ref_mem [0:RAM_WORDS-1];
    bit ref_last_d = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_inr(input logic [31:0] a);
        return (a - BASE) < 32'd8192;
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // One isolated access, with cycle-exact checks of RAM pins and the ready pulse.
    task automatic xfer(input bit is_d, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, output logic [31:0] rdata);
        bit inr;
        bit wr;
        int idx;
        logic [31:0] exp_rd;
        inr    = ref_inr(addr);
        wr     = is_d && (wstrb != 4'b0000);
        idx    = inr ? ref_idx(addr) : 0;
        exp_rd = (inr && !wr) ? ref_mem[idx] : 32'h0;
        @(posedge clock); #1;
        d_wstrb = wstrb;
        d_wdata = wdata;
        if (is_d) begin
            d_valid = 1'b1;
            d_addr  = addr;
        end else begin
            i_valid = 1'b1;
            i_addr  = addr;
        end
        @(negedge clock);
        chk("idle_en", {30'b0, ram_rden, ram_wren}, 32'h0);
        @(negedge clock);
        chk("issue_rden", 32'(ram_rden), 32'(inr && !wr));
        chk("issue_wren", 32'(ram_wren), 32'(inr && wr));
        chk("issue_rdy", {30'b0, i_ready, d_ready}, 32'h0);
        if (inr) chk("ram_addr", 32'(ram_address), 32'(idx));
        if (inr && wr) begin
            chk("byteena", 32'(ram_byteena), 32'(wstrb));
            chk("ram_data", ram_data, wdata);
        end
        @(negedge clock);
        chk("ready", {30'b0, i_ready, d_ready}, is_d ? 32'd1 : 32'd2);
        chk("bus_err", 32'(bus_err), 32'(!inr));
        chk("resp_en", {30'b0, ram_rden, ram_wren}, 32'h0);
        rdata = is_d ? d_rdata : i_rdata;
        if (!wr) chk("rdata", rdata, exp_rd);
        @(posedge clock); #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        d_wstrb = 4'b0000;
        if (inr && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        ref_last_d = is_d;
    endtask

    // Both ports hold read requests until served ni / nd times; grant order and spacing checked.
    task automatic arb(input int ni, input int nd);
        int ri;
        int rd;
        int k;
        int cyc;
        int last_cyc;
        bit last_d;
        bit pick_d;
        bit port;
        bit exp_q[$];
        ri = ni;
        rd = nd;
        last_d = ref_last_d;
        while (ri > 0 || rd > 0) begin
            if (ri > 0 && rd > 0) pick_d = RR_MODE ? !last_d : 1'b1;
            else                  pick_d = (rd > 0);
            exp_q.push_back(pick_d);
            if (pick_d) rd--; else ri--;
            last_d = pick_d;
        end
        ri = ni;
        rd = nd;
        k = 0;
        cyc = 0;
        last_cyc = 0;
        @(posedge clock); #1;
        i_addr  = BASE + 32'd12;
        d_addr  = BASE + 32'd20;
        d_wstrb = 4'b0000;
        i_valid = (ri > 0);
        d_valid = (rd > 0);
        while ((ri > 0 || rd > 0) && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (i_ready || d_ready) begin
                chk("arb_one_ready", 32'(i_ready & d_ready), 32'h0);
                port = d_ready;
                if (k < exp_q.size()) chk("arb_port", 32'(port), 32'(exp_q[k]));
                else                  chk("arb_extra_grant", 32'(k), 32'(exp_q.size()));
                chk("arb_rdata", port ? d_rdata : i_rdata, port ? ref_mem[5] : ref_mem[3]);
                chk("arb_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                k++;
                @(posedge clock); #1;
                if (port) rd--; else ri--;
                i_valid = (ri > 0);
                d_valid = (rd > 0);
                ref_last_d = port;
            end
        end
        if (cyc >= 200) chk("arb_timeout", 32'(cyc), 32'd0);
        chk("arb_count", 32'(k), 32'(exp_q.size()));
        i_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdv;
        logic [31:0] a;
        logic [3:0]  ws;
        bit          isd;
        int          widx;

        resetn  = 1'b0;
        i_valid = 1'b0;
        i_addr  = 32'h0;
        d_valid = 1'b0;
        d_addr  = 32'h0;
        d_wstrb = 4'b0000;
        d_wdata = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_ready", {30'b0, i_ready, d_ready}, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        chk("rst_en", {30'b0, ram_rden, ram_wren}, 32'h0);
        chk("rst_addr", 32'(ram_address), 32'h0);
        chk("rst_byteena", 32'(ram_byteena), 32'h0);
        chk("rst_data", ram_data, 32'h0);
        resetn = 1'b1;

        for (int w = 0; w < 64; w++) begin
            xfer(1'b1, BASE + 32'(w * 4), 4'hF, $urandom, rdv);
        end

        xfer(1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, rdv);
        xfer(1'b1, BASE + 32'h10, 4'h0, 32'h0, rdv);
        chk("wr_then_rd", rdv, 32'hDEADBEEF);
        xfer(1'b1, BASE + 32'h10, 4'b0100, 32'h00AA0000, rdv);
        xfer(1'b1, BASE + 32'h10, 4'h0, 32'h0, rdv);
        chk("byte_wr_rd", rdv, 32'hDEAABEEF);

        xfer(1'b1, BASE + 32'h2000, 4'h0, 32'h0, rdv);
        xfer(1'b1, BASE + 32'h2000, 4'hF, 32'hBAD0BAD0, rdv);
        xfer(1'b0, BASE + 32'h2004, 4'h0, 32'h0, rdv);
        xfer(1'b1, BASE, 4'h0, 32'h0, rdv);

        xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, rdv);
        chk("ifetch_rd", rdv, 32'hDEAABEEF);

        arb(4, 4);
        arb(1, 1);
        arb(2, 3);

        for (int t = 0; t < 60; t++) begin
            isd  = 1'($urandom_range(0, 1));
            widx = $urandom_range(0, 63);
            a    = BASE + 32'(widx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? BASE + 32'h2000 + 32'(widx * 4) : BASE - 32'd4;
            end
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            xfer(isd, a, ws, $urandom, rdv);
        end

        @(posedge clock); #1;
        d_valid = 1'b1;
        d_addr  = BASE + 32'h20;
        d_wstrb = 4'hF;
        d_wdata = 32'h12345678;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_wren", 32'(ram_wren), 32'h1);
        resetn = 1'b0;
        #1;
        chk("midrst_en", {30'b0, ram_rden, ram_wren}, 32'h0);
        chk("midrst_ready", {30'b0, i_ready, d_ready}, 32'h0);
        chk("midrst_bus_err", 32'(bus_err), 32'h0);
        chk("midrst_addr", 32'(ram_address), 32'h0);
        d_valid = 1'b0;
        d_wstrb = 4'h0;
        @(negedge clock);
        chk("midrst_ready_hold", {30'b0, i_ready, d_ready}, 32'h0);
        resetn = 1'b1;
        ref_last_d = 1'b0;
        xfer(1'b1, BASE, 4'h0, 32'h0, rdv);
        xfer(1'b1, BASE + 32'h20, 4'h0, 32'h0, rdv);
        arb(2, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
